// File: rtl/cv32e40x_sleep_ctrl.sv
// Sleep/wake sequencer feeding the core clock gate enable: holds the clock off until boot,
// gates it after a retired WFI once fetch/LSU drain, and restores it on interrupt or debug wake.
module cv32e40x_sleep_ctrl #(
  parameter int unsigned IDLE_CYCLES = 2,
  parameter int unsigned WAKE_DELAY  = 1
) (
  input  logic clk_ungated_i,
  input  logic rst_i,
  input  logic fetch_enable_i,
  input  logic wfi_req_i,
  input  logic if_busy_i,
  input  logic lsu_busy_i,
  input  logic wake_irq_i,
  input  logic debug_req_i,
  output logic clock_en_o,
  output logic core_sleep_o,
  output logic wake_o
);

  if (IDLE_CYCLES < 1 || IDLE_CYCLES > 15) begin : g_bad_idle_cycles
    $error("cv32e40x_sleep_ctrl: IDLE_CYCLES must be in 1..15");
  end
  if (WAKE_DELAY < 1 || WAKE_DELAY > 15) begin : g_bad_wake_delay
    $error("cv32e40x_sleep_ctrl: WAKE_DELAY must be in 1..15");
  end

  localparam logic [3:0] IDLE_LAST = 4'(IDLE_CYCLES - 1);
  localparam logic [3:0] WAKE_LAST = 4'(WAKE_DELAY - 1);

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    SLEEP = 3'd3,
    WAKE  = 3'd4
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       wake_ev;

  assign wake_ev = wake_irq_i | debug_req_i;

  // Outputs are assigned alongside every state change so they always match the new state.
  always_ff @(posedge clk_ungated_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= BOOT;
      cnt          <= 4'd0;
      clock_en_o   <= 1'b0;
      core_sleep_o <= 1'b0;
      wake_o       <= 1'b0;
    end else begin
      wake_o <= 1'b0;
      case (state)
        BOOT: begin
          if (fetch_enable_i) begin
            state      <= RUN;
            clock_en_o <= 1'b1;
          end
        end
        RUN: begin
          if (wfi_req_i && !wake_ev) begin
            state <= DRAIN;
            cnt   <= 4'd0;
          end
        end
        DRAIN: begin
          if (wake_ev || !wfi_req_i) begin
            state <= RUN;
            cnt   <= 4'd0;
          end else if (if_busy_i || lsu_busy_i) begin
            cnt <= 4'd0;
          end else if (cnt == IDLE_LAST) begin
            state        <= SLEEP;
            cnt          <= 4'd0;
            clock_en_o   <= 1'b0;
            core_sleep_o <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        SLEEP: begin
          if (wake_ev) begin
            state      <= WAKE;
            cnt        <= 4'd0;
            clock_en_o <= 1'b1;
          end
        end
        WAKE: begin
          // Wake is committed once started; a dropped wake_ev does not send us back to SLEEP.
          if (cnt == WAKE_LAST) begin
            state        <= RUN;
            cnt          <= 4'd0;
            core_sleep_o <= 1'b0;
            wake_o       <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state        <= BOOT;
          cnt          <= 4'd0;
          clock_en_o   <= 1'b0;
          core_sleep_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cv32e40x_sleep_ctrl.sv
// Directed bench for cv32e40x_sleep_ctrl: expected {clock_en, core_sleep, wake} pushed
// to a scoreboard as stimulus is driven, popped and asserted after the following edge.
module tb_cv32e40x_sleep_ctrl;

  logic clk = 1'b0;
  logic rst, fetch_enable, wfi_req, if_busy, lsu_busy, wake_irq, debug_req;
  logic ce1, sl1, wk1;
  logic ce4, sl4, wk4;

  int n_assert = 0;
  int n_fail   = 0;

  string      tag_q[$];
  logic [2:0] val_q[$];
  bit         slow_q[$];

  always #5 clk = ~clk;

  cv32e40x_sleep_ctrl #(.IDLE_CYCLES(2), .WAKE_DELAY(1)) dut (
    .clk_ungated_i (clk),
    .rst_i         (rst),
    .fetch_enable_i(fetch_enable),
    .wfi_req_i     (wfi_req),
    .if_busy_i     (if_busy),
    .lsu_busy_i    (lsu_busy),
    .wake_irq_i    (wake_irq),
    .debug_req_i   (debug_req),
    .clock_en_o    (ce1),
    .core_sleep_o  (sl1),
    .wake_o        (wk1)
  );

  cv32e40x_sleep_ctrl #(.IDLE_CYCLES(2), .WAKE_DELAY(4)) dut4 (
    .clk_ungated_i (clk),
    .rst_i         (rst),
    .fetch_enable_i(fetch_enable),
    .wfi_req_i     (wfi_req),
    .if_busy_i     (if_busy),
    .lsu_busy_i    (lsu_busy),
    .wake_irq_i    (wake_irq),
    .debug_req_i   (debug_req),
    .clock_en_o    (ce4),
    .core_sleep_o  (sl4),
    .wake_o        (wk4)
  );

  task automatic expect1(input string tag, input logic [2:0] val);
    tag_q.push_back(tag); val_q.push_back(val); slow_q.push_back(1'b0);
  endtask

  task automatic expect4(input string tag, input logic [2:0] val);
    tag_q.push_back(tag); val_q.push_back(val); slow_q.push_back(1'b1);
  endtask

  task automatic check_q();
    string      tag;
    logic [2:0] exp_v;
    logic [2:0] obs;
    bit         slow;
    while (tag_q.size() > 0) begin
      tag   = tag_q.pop_front();
      exp_v = val_q.pop_front();
      slow  = slow_q.pop_front();
      obs   = slow ? {ce4, sl4, wk4} : {ce1, sl1, wk1};
      n_assert++;
      assert (obs === exp_v) else begin
        n_fail++;
        $error("FAIL %s observed={ce,sl,wk}=%b expected=%b", tag, obs, exp_v);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_q();
  endtask

  initial begin
    rst = 1'b1; fetch_enable = 1'b0; wfi_req = 1'b0; if_busy = 1'b0;
    lsu_busy = 1'b0; wake_irq = 1'b0; debug_req = 1'b0;
    tick(); tick();
    expect1("reset_state", 3'b000);
    expect4("reset_state_d4", 3'b000);
    check_q();
    rst = 1'b0;

    // T1 boot
    for (int i = 0; i < 5; i++) begin
      expect1("boot_hold", 3'b000);
      tick();
    end
    fetch_enable = 1'b1;
    expect1("boot_enable", 3'b100);
    tick();
    fetch_enable = 1'b0;
    expect1("boot_sticky", 3'b100);
    tick();

    // T2 sleep/wake with defaults
    wfi_req = 1'b1;
    expect1("t2_drain", 3'b100);  tick();
    expect1("t2_cnt1", 3'b100);   tick();
    expect1("t2_sleep", 3'b010);  tick();
    expect1("t2_sleep_hold", 3'b010); tick();
    wake_irq = 1'b1;
    expect1("t2_wake", 3'b110);   tick();
    wake_irq = 1'b0; wfi_req = 1'b0;
    expect1("t2_wake_pulse", 3'b101); tick();
    expect1("t2_run", 3'b100);    tick();

    // T3 busy drain: lsu busy holds cnt, if_busy pulse restarts it
    wfi_req = 1'b1;
    expect1("t3_drain", 3'b100);  tick();
    lsu_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect1("t3_lsu_busy", 3'b100);
      tick();
    end
    lsu_busy = 1'b0; if_busy = 1'b1;
    expect1("t3_if_busy", 3'b100); tick();
    if_busy = 1'b0;
    expect1("t3_cnt1", 3'b100);   tick();
    expect1("t3_sleep", 3'b010);  tick();
    wake_irq = 1'b1;
    expect1("t3_wake", 3'b110);   tick();
    wake_irq = 1'b0; wfi_req = 1'b0;
    expect1("t3_wake_pulse", 3'b101); tick();
    expect1("t3_run", 3'b100);    tick();

    // T4 debug abort at terminal count, then wfi+wake in RUN and wfi drop in DRAIN
    wfi_req = 1'b1;
    expect1("t4_drain", 3'b100);  tick();
    expect1("t4_cnt1", 3'b100);   tick();
    debug_req = 1'b1;
    expect1("t4_abort", 3'b100);  tick();
    debug_req = 1'b0;
    expect1("t4_redrain", 3'b100); tick();
    wfi_req = 1'b0;
    expect1("t4_wfi_drop", 3'b100); tick();
    expect1("t4_run", 3'b100);    tick();
    wfi_req = 1'b1; wake_irq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect1("t4_wfi_with_wake", 3'b100);
      tick();
    end
    wfi_req = 1'b0; wake_irq = 1'b0;
    expect1("t4_settle", 3'b100); tick();

    // T5 WAKE_DELAY=4 instance
    rst = 1'b1; #1;
    expect4("t5_reset", 3'b000);
    check_q();
    rst = 1'b0;
    fetch_enable = 1'b1;
    expect4("t5_boot", 3'b100);   tick();
    fetch_enable = 1'b0; wfi_req = 1'b1;
    expect4("t5_drain", 3'b100);  tick();
    expect4("t5_cnt1", 3'b100);   tick();
    expect4("t5_sleep", 3'b010);  tick();
    wake_irq = 1'b1;
    expect4("t5_wake_j", 3'b110); tick();
    wake_irq = 1'b0; wfi_req = 1'b0;
    expect4("t5_wake_j1", 3'b110); tick();
    expect4("t5_wake_j2", 3'b110); tick();
    expect4("t5_wake_j3", 3'b110); tick();
    expect4("t5_wake_pulse", 3'b101); tick();
    expect4("t5_run", 3'b100);    tick();

    // T6 async reset from SLEEP, BOOT ignores wake until fetch enable
    wfi_req = 1'b1;
    expect1("t6_drain", 3'b100);  tick();
    expect1("t6_cnt1", 3'b100);   tick();
    expect1("t6_sleep", 3'b010);  tick();
    #2 rst = 1'b1;
    #1;
    expect1("t6_async_reset", 3'b000);
    expect4("t6_async_reset_d4", 3'b000);
    check_q();
    #2 rst = 1'b0;
    wfi_req = 1'b0; wake_irq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect1("t6_boot_ignores_wake", 3'b000);
      tick();
    end
    fetch_enable = 1'b1;
    expect1("t6_reboot", 3'b100); tick();
    fetch_enable = 1'b0; wake_irq = 1'b0;
    expect1("t6_run", 3'b100);    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
